// File: rtl/param_bus_pkg.sv
// Shared types and sizing helpers for the parameter register bus arbiter.
package param_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        WAIT,
        DONE
    } state_t;

    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned PTR_W_DEF   = $clog2(NUM_REQ_DEF);

    // Priority pointer / grant index width for a given requester count.
    function automatic int unsigned ptr_w(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/param_bus_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or above ptr_i, wrapping.
module rr_pick
    import param_bus_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned PTR_W   = ptr_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [PTR_W-1:0]   gnt_idx_o,
    output logic               any_req_o
);

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                  input int unsigned      off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return PTR_W'(sum);
    endfunction

    // Scan from the farthest offset down so the nearest hit overwrites.
    always_comb begin
        gnt_idx_o = '0;
        any_req_o = 1'b0;
        for (int unsigned k = NUM_REQ; k > 0; k--) begin
            if (req_i[wrap_idx(ptr_i, k - 1)]) begin
                gnt_idx_o = wrap_idx(ptr_i, k - 1);
                any_req_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/param_bus_arbiter.sv
// Round-robin arbiter/sequencer for the shared parameter register bus:
// grants one requester, times the strobe against the registered decoder, acks.
module param_bus_arbiter
    import param_bus_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        req_we_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]        ack_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic [ADDR_W-1:0]         bus_addr_o,
    output logic [DATA_W-1:0]         bus_wdata_o,
    output logic                      bus_we_o,
    output logic                      bus_rd_o,
    input  logic [DATA_W-1:0]         bus_rdata_i,
    output logic                      busy_o
);

    localparam int unsigned PTR_W = ptr_w(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    gnt_q, gnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic                bus_we_q, bus_we_d;
    logic                bus_rd_q, bus_rd_d;
    logic                busy_q, busy_d;

    logic [PTR_W-1:0]    pick_idx;
    logic                any_req;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req_i     (req_i),
        .ptr_i     (ptr_q),
        .gnt_idx_o (pick_idx),
        .any_req_o (any_req)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; the WAIT counter is sequencing state, so it lives here too.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:   if (any_req) state_d = SETUP;
            SETUP:  state_d = ACCESS;
            ACCESS: begin
                if (we_q) begin
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(RD_LAT);
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant latching, read capture and next values of the registered outputs.
    always_comb begin
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        if (state_q == IDLE && any_req) begin
            gnt_d = pick_idx;
            ptr_d = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (pick_idx == PTR_W'(i)) begin
                    we_d    = req_we_i[i];
                    addr_d  = req_addr_i[i*ADDR_W +: ADDR_W];
                    wdata_d = req_wdata_i[i*DATA_W +: DATA_W];
                end
            end
        end
        if (state_q == WAIT && cnt_q == CNT_W'(1)) begin
            rdata_d = bus_rdata_i;
        end
        ack_d    = (state_d == DONE) ? (NUM_REQ'(1) << gnt_q) : '0;
        bus_we_d = (state_d == ACCESS) &&  we_q;
        bus_rd_d = (state_d == ACCESS) && !we_q;
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q    <= '0;
            gnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
            ack_q    <= '0;
            bus_we_q <= 1'b0;
            bus_rd_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            bus_we_q <= bus_we_d;
            bus_rd_q <= bus_rd_d;
            busy_q   <= busy_d;
        end
    end

    assign ack_o       = ack_q;
    assign rdata_o     = rdata_q;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;
    assign bus_we_o    = bus_we_q;
    assign bus_rd_o    = bus_rd_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_param_bus_arbiter.sv
// Directed bench for param_bus_arbiter with a two-stage slave read pipeline.
module tb_param_bus_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned RD_LAT  = 2;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         rdata;
    logic [ADDR_W-1:0]         bus_addr;
    logic [DATA_W-1:0]         bus_wdata;
    logic                      bus_we;
    logic                      bus_rd;
    logic [DATA_W-1:0]         bus_rdata;
    logic                      busy;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    param_bus_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .RD_LAT  (RD_LAT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_i       (req),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .ack_o       (ack),
        .rdata_o     (rdata),
        .bus_addr_o  (bus_addr),
        .bus_wdata_o (bus_wdata),
        .bus_we_o    (bus_we),
        .bus_rd_o    (bus_rd),
        .bus_rdata_i (bus_rdata),
        .busy_o      (busy)
    );

    // Slave model: register file with data valid two cycles after bus_rd, 0 otherwise.
    logic [DATA_W-1:0] mem [8];
    logic [DATA_W-1:0] d1, d2;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) mem[i] <= '0;
            mem[3] <= 8'h5C;
            d1     <= '0;
            d2     <= '0;
        end else begin
            if (bus_we) mem[bus_addr] <= bus_wdata;
            d1 <= bus_rd ? mem[bus_addr] : 8'h00;
            d2 <= d1;
        end
    end
    assign bus_rdata = d2;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic set_req(input int i, input logic we, input logic [2:0] a, input logic [7:0] d);
        req_we[i]          = we;
        req_addr[i*3 +: 3] = a;
        req_wdata[i*8 +: 8] = d;
        req[i]             = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, ".ack"},   32'(ack),       32'h0);
        check_val({tag, ".we"},    32'(bus_we),    32'h0);
        check_val({tag, ".rd"},    32'(bus_rd),    32'h0);
        check_val({tag, ".busy"},  32'(busy),      32'h0);
        check_val({tag, ".addr"},  32'(bus_addr),  32'h0);
        check_val({tag, ".wdata"}, 32'(bus_wdata), 32'h0);
        check_val({tag, ".rdata"}, 32'(rdata),     32'h0);
    endtask

    // Called at the negedge of cycle 0 (IDLE cycle with req sampled); walks n cycles.
    task automatic txn(input string tag, input int n, input int we_c, input int rd_c,
                       input int ack_c, input logic [3:0] ack_e,
                       input int drop_c, input logic [3:0] drop_m,
                       input logic [2:0] addr_e, input logic [7:0] wdata_e,
                       input logic [7:0] rdata_e);
        for (int c = 0; c < n; c++) begin
            if (c > 0) @(negedge clk);
            check_val($sformatf("%s.c%0d.ack", tag, c), 32'(ack), (c == ack_c) ? 32'(ack_e) : 32'h0);
            check_val($sformatf("%s.c%0d.we", tag, c), 32'(bus_we), 32'(c == we_c));
            check_val($sformatf("%s.c%0d.rd", tag, c), 32'(bus_rd), 32'(c == rd_c));
            check_val($sformatf("%s.c%0d.busy", tag, c), 32'(busy), 32'(c >= 1 && c <= ack_c));
            if (ack_c >= 0 && c == 1)
                check_val($sformatf("%s.addr", tag), 32'(bus_addr), 32'(addr_e));
            if (c == we_c)
                check_val($sformatf("%s.wdata", tag), 32'(bus_wdata), 32'(wdata_e));
            if (c == ack_c)
                check_val($sformatf("%s.rdata", tag), 32'(rdata), 32'(rdata_e));
            if (c == drop_c) req = req & ~drop_m;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        reset_n   = 1'b0;
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // All four requesters held high: grants 0,1,2,3,0
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 3'(4 + i), 8'(16 + i));
        for (int k = 0; k < 5; k++) begin
            g = k % 4;
            if (k > 0) @(negedge clk);
            txn($sformatf("rr%0d", k), 4, 2, -1, 3, 4'(1 << g), (k == 4) ? 3 : -1, 4'hF,
                3'(4 + g), 8'(16 + g), 8'h00);
        end

        // Single write, requester 2
        @(negedge clk);
        set_req(2, 1'b1, 3'd5, 8'hA7);
        txn("wr", 5, 2, -1, 3, 4'b0100, 3, 4'b0100, 3'd5, 8'hA7, 8'h00);

        // Single read, requester 1 (leaves ptr at 2)
        @(negedge clk);
        set_req(1, 1'b0, 3'd3, 8'h00);
        txn("rd", 7, -1, 2, 5, 4'b0010, 5, 4'b0010, 3'd3, 8'h00, 8'h5C);

        // Fairness from ptr=2: 3 before 0; writes keep rdata
        @(negedge clk);
        set_req(0, 1'b1, 3'd1, 8'h21);
        set_req(3, 1'b1, 3'd6, 8'h63);
        txn("fair3", 4, 2, -1, 3, 4'b1000, 3, 4'b1000, 3'd6, 8'h63, 8'h5C);
        @(negedge clk);
        txn("fair0", 5, 2, -1, 3, 4'b0001, 3, 4'b0001, 3'd1, 8'h21, 8'h5C);

        // Requester drops req at cycle 1: transaction still completes
        @(negedge clk);
        set_req(0, 1'b1, 3'd2, 8'h3C);
        txn("drop", 7, 2, -1, 3, 4'b0001, 1, 4'b0001, 3'd2, 8'h3C, 8'h5C);
        check_val("drop.addr_hold", 32'(bus_addr), 32'd2);

        // Reset asserted during WAIT
        @(negedge clk);
        set_req(2, 1'b0, 3'd5, 8'h00);
        txn("rstw", 3, -1, 2, 99, 4'b0000, -1, 4'b0000, 3'd5, 8'h00, 8'h00);
        @(negedge clk);
        reset_n = 1'b0;
        req     = '0;
        #1;
        check_zero("rstw.async");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        txn("postrst", 6, -1, -1, -1, 4'b0000, -1, 4'b0000, 3'd0, 8'h00, 8'h00);

        // First grant after reset searches from requester 0
        @(negedge clk);
        set_req(1, 1'b1, 3'd4, 8'h44);
        set_req(3, 1'b1, 3'd7, 8'h77);
        txn("rst1", 4, 2, -1, 3, 4'b0010, 3, 4'b0010, 3'd4, 8'h44, 8'h00);
        @(negedge clk);
        txn("rst3", 5, 2, -1, 3, 4'b1000, 3, 4'b1000, 3'd7, 8'h77, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
